// File: rtl/puzzle_move_writer.sv
// Write-side move controller for the 5-puzzle register file: read board/count/history,
// validate and apply one blank move, write all three back. Optional: PUZZLE_SOLVED_DETECT_EN.
module puzzle_move_writer #(
  parameter int DW        = 40,
  parameter int BOARD_REG = 0,
  parameter int CNT_REG   = 1,
  parameter int ORD_REG   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_dir,
  output logic [3:0]    rf_src0,
  output logic [3:0]    rf_src1,
  input  logic [DW-1:0] rf_data0,
  input  logic [DW-1:0] rf_data1,
  output logic          rf_we,
  output logic [3:0]    rf_dst,
  output logic [DW-1:0] rf_wdata,
  output logic          done,
  output logic          illegal,
  output logic          solved
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, CALC, WR_BRD, WR_CNT, WR_ORD, DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      dir_q;
  logic [17:0]     board_q;
  logic [DW-1:0]   cnt_q;
  logic [DW-3:0]   hist_q;
  logic            illegal_q;

  logic [2:0]      blank_pos, tgt_pos, tile;
  logic            found, legal;
  logic [17:0]     swapped;

  // Scan from the top cell down so the lowest-index blank wins.
  always_comb begin
    found     = 1'b0;
    blank_pos = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (board_q[17-3*i -: 3] == 3'd0) begin
        found     = 1'b1;
        blank_pos = 3'(i);
      end
    end
  end

  always_comb begin
    legal   = 1'b0;
    tgt_pos = blank_pos;
    case (dir_q)
      2'd0: begin legal = blank_pos >= 3'd3; tgt_pos = blank_pos - 3'd3; end
      2'd1: begin legal = blank_pos <  3'd3; tgt_pos = blank_pos + 3'd3; end
      2'd2: begin legal = (blank_pos != 3'd0) && (blank_pos != 3'd3); tgt_pos = blank_pos - 3'd1; end
      default: begin legal = (blank_pos != 3'd2) && (blank_pos != 3'd5); tgt_pos = blank_pos + 3'd1; end
    endcase
    legal = legal && found;
  end

  // Blank cell already holds 0, so the swap only moves the target tile into it.
  always_comb begin
    tile    = 3'd0;
    swapped = board_q;
    for (int i = 0; i < 6; i++)
      if (3'(i) == tgt_pos) tile = board_q[17-3*i -: 3];
    for (int i = 0; i < 6; i++) begin
      if (3'(i) == blank_pos)    swapped[17-3*i -: 3] = tile;
      else if (3'(i) == tgt_pos) swapped[17-3*i -: 3] = 3'd0;
    end
  end

  // NOTE: state and data registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dir_q     <= 2'd0;
      board_q   <= 18'd0;
      cnt_q     <= '0;
      hist_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (cmd_valid) dir_q <= cmd_dir;
        RD_A: begin
          board_q <= rf_data0[17:0];
          cnt_q   <= rf_data1;
        end
        RD_B: hist_q    <= rf_data0[DW-3:0];
        CALC: illegal_q <= !legal;
        default: ;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rf_src0   = 4'd0;
    rf_src1   = 4'd0;
    rf_we     = 1'b0;
    rf_dst    = 4'd0;
    rf_wdata  = '0;
    done      = 1'b0;
    illegal   = 1'b0;
    solved    = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = RD_A;
      end
      RD_A: begin
        rf_src0 = 4'(BOARD_REG);
        rf_src1 = 4'(CNT_REG);
        state_d = RD_B;
      end
      RD_B: begin
        rf_src0 = 4'(ORD_REG);
        state_d = CALC;
      end
      CALC: state_d = legal ? WR_BRD : DONE;
      WR_BRD: begin
        rf_we    = 1'b1;
        rf_dst   = 4'(BOARD_REG);
        rf_wdata = {{(DW-18){1'b0}}, swapped};
        state_d  = WR_CNT;
      end
      WR_CNT: begin
        rf_we    = 1'b1;
        rf_dst   = 4'(CNT_REG);
        rf_wdata = cnt_q + DW'(1);
        state_d  = WR_ORD;
      end
      WR_ORD: begin
        rf_we    = 1'b1;
        rf_dst   = 4'(ORD_REG);
        rf_wdata = {hist_q, dir_q};
        state_d  = DONE;
      end
      default: begin
        done    = 1'b1;
        illegal = illegal_q;
`ifdef PUZZLE_SOLVED_DETECT_EN
        solved  = !illegal_q && (swapped == 18'o123450);
`endif
        state_d = IDLE;
      end
    endcase
  end

endmodule
